// File: rtl/rv_test_monitor_pkg.sv
// Shared definitions for the riscv-tests pass/fail monitor.
//   - GPR address/data widths of the snooped register-file writeback port
//   - default indices of the case, done and pass registers (x3/x26/x27)
//   - default done-trigger and pass values
//   - monitor FSM state encoding
//   - gpr_hit(): "this writeback targets GPR idx" decode, shared by all snoopers
package rv_tb_pkg;

  localparam int unsigned GPR_AW = 5;
  localparam int unsigned GPR_DW = 32;

  localparam int unsigned DEF_CASE_REG = 3;
  localparam int unsigned DEF_DONE_REG = 26;
  localparam int unsigned DEF_PASS_REG = 27;

  localparam logic [GPR_DW-1:0] DEF_DONE_VAL = 32'd1;
  localparam logic [GPR_DW-1:0] DEF_PASS_VAL = 32'd1;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EVAL   = 2'd2,
    ST_DONE   = 2'd3
  } mon_state_e;

  // x0 is hard-wired to zero in the core, so an index of 0 never matches.
  function automatic logic gpr_hit(input logic              we,
                                   input logic [GPR_AW-1:0] addr,
                                   input int unsigned       idx);
    return we && (idx != 0) && (addr == GPR_AW'(idx));
  endfunction

endpackage

// File: rtl/rv_test_monitor_if.sv
// Register-file writeback port as seen by the monitor.
//   wb_we_i   : write enable
//   wb_addr_i : destination GPR index
//   wb_data_i : value being written
// master: the core (or testbench) driving the writeback port.
// slave : the monitor snooping it.
interface rv_test_monitor_if;
  import rv_tb_pkg::*;

  logic              wb_we_i;
  logic [GPR_AW-1:0] wb_addr_i;
  logic [GPR_DW-1:0] wb_data_i;

  modport master (output wb_we_i, output wb_addr_i, output wb_data_i);
  modport slave  (input  wb_we_i, input  wb_addr_i, input  wb_data_i);

endinterface

// File: rtl/rv_reg_shadow.sv
// Single-register write snoop: keeps a copy of GPR INDEX by watching the
// writeback port.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to 0 (wins over any same-cycle write)
//   freeze     : hold the current value, ignore writes
//   we/addr/data : writeback port
//   value      : shadowed register value (constant 0 when INDEX is 0)
module rv_reg_shadow
  import rv_tb_pkg::*;
#(
  parameter int unsigned INDEX = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              freeze,
  input  logic              we,
  input  logic [GPR_AW-1:0] addr,
  input  logic [GPR_DW-1:0] data,
  output logic [GPR_DW-1:0] value
);

  generate
    if (INDEX == 0) begin : g_zero
      assign value = '0;
    end else begin : g_hold
      logic [GPR_DW-1:0] value_q;

      // NOTE: clocked state uses non-blocking assignment so every register
      // samples pre-edge values, independent of process evaluation order.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          value_q <= '0;
        end else if (clear) begin
          value_q <= '0;
        end else if (!freeze && gpr_hit(we, addr, INDEX)) begin
          value_q <= data;
        end
      end

      assign value = value_q;
    end
  endgenerate

endmodule

// File: rtl/rv_test_monitor.sv
// Pass/fail monitor for riscv-tests style programs. Snoops the register-file
// writeback port, shadows the case and pass registers, and after the done
// register is written with DONE_VAL waits a settle window and reports a
// sticky verdict. A watchdog ends a test that never signals completion.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear_i      : synchronous restart (all state to 0, back to RUN)
//   wb           : writeback port (slave modport)
//   done_o       : verdict available (pass, fail or timeout)
//   pass_o       : test passed
//   fail_o       : test failed or timed out
//   timeout_o    : watchdog expired
//   fail_case_o  : case register value at evaluation, 0 on pass
//   cycle_cnt_o  : cycles spent in RUN + SETTLE, frozen once done
module rv_test_monitor
  import rv_tb_pkg::*;
#(
  parameter int unsigned        CASE_REG       = DEF_CASE_REG,
  parameter int unsigned        DONE_REG       = DEF_DONE_REG,
  parameter int unsigned        PASS_REG       = DEF_PASS_REG,
  parameter logic [GPR_DW-1:0]  DONE_VAL       = DEF_DONE_VAL,
  parameter logic [GPR_DW-1:0]  PASS_VAL       = DEF_PASS_VAL,
  parameter int unsigned        SETTLE_CYCLES  = 2,
  parameter int unsigned        TIMEOUT_CYCLES = 100000,
  parameter int unsigned        CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  rv_test_monitor_if.slave  wb,
  output logic              done_o,
  output logic              pass_o,
  output logic              fail_o,
  output logic              timeout_o,
  output logic [GPR_DW-1:0] fail_case_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES);
  localparam bit               WDOG_EN     = (TIMEOUT_CYCLES != 0);
  // Watchdog fires while the counter still shows the last permitted cycle,
  // so the frozen count reads TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0] WDOG_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  mon_state_e        state_q, state_d;
  logic [7:0]        settle_q, settle_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              pass_flag_q, pass_flag_d;
  logic              fail_flag_q, fail_flag_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic [GPR_DW-1:0] fail_case_q, fail_case_d;

  logic [GPR_DW-1:0] case_val;
  logic [GPR_DW-1:0] pass_val;
  logic              shadow_freeze;
  logic              trigger;
  logic              wdog_hit;

  // Shadows follow the program through RUN and SETTLE so a pass write that
  // lands in the last settle cycle still counts; they stop once evaluated.
  assign shadow_freeze = (state_q == ST_EVAL) || (state_q == ST_DONE);

  rv_reg_shadow #(.INDEX(CASE_REG)) u_case_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear_i),
    .freeze (shadow_freeze),
    .we     (wb.wb_we_i),
    .addr   (wb.wb_addr_i),
    .data   (wb.wb_data_i),
    .value  (case_val)
  );

  rv_reg_shadow #(.INDEX(PASS_REG)) u_pass_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear_i),
    .freeze (shadow_freeze),
    .we     (wb.wb_we_i),
    .addr   (wb.wb_addr_i),
    .data   (wb.wb_data_i),
    .value  (pass_val)
  );

  assign trigger  = gpr_hit(wb.wb_we_i, wb.wb_addr_i, DONE_REG) &&
                    (wb.wb_data_i == DONE_VAL);
  assign wdog_hit = WDOG_EN && (cnt_q == WDOG_LAST);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      settle_q    <= '0;
      cnt_q       <= '0;
      pass_flag_q <= 1'b0;
      fail_flag_q <= 1'b0;
      tmo_flag_q  <= 1'b0;
      fail_case_q <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      pass_flag_q <= pass_flag_d;
      fail_flag_q <= fail_flag_d;
      tmo_flag_q  <= tmo_flag_d;
      fail_case_q <= fail_case_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block is given a default before the case
    // so no path leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    settle_d    = settle_q;
    cnt_d       = cnt_q;
    pass_flag_d = pass_flag_q;
    fail_flag_d = fail_flag_q;
    tmo_flag_d  = tmo_flag_q;
    fail_case_d = fail_case_q;

    case (state_q)
      ST_RUN: begin
        if (trigger) begin
          state_d  = ST_SETTLE;
          settle_d = SETTLE_LOAD;
          cnt_d    = cnt_inc;
        end else if (wdog_hit) begin
          state_d     = ST_DONE;
          tmo_flag_d  = 1'b1;
          fail_flag_d = 1'b1;
          fail_case_d = case_val;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_SETTLE: begin
        cnt_d = cnt_inc;
        if (settle_q == 8'd0) begin
          state_d = ST_EVAL;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end

      ST_EVAL: begin
        state_d = ST_DONE;
        if (pass_val == PASS_VAL) begin
          pass_flag_d = 1'b1;
          fail_case_d = '0;
        end else begin
          fail_flag_d = 1'b1;
          fail_case_d = case_val;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Restart overrides whatever the FSM decided this cycle.
    if (clear_i) begin
      state_d     = ST_RUN;
      settle_d    = '0;
      cnt_d       = '0;
      pass_flag_d = 1'b0;
      fail_flag_d = 1'b0;
      tmo_flag_d  = 1'b0;
      fail_case_d = '0;
    end
  end

  assign pass_o      = pass_flag_q;
  assign fail_o      = fail_flag_q;
  assign timeout_o   = tmo_flag_q;
  assign done_o      = pass_flag_q | fail_flag_q;
  assign fail_case_o = fail_case_q;
  assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_rv_test_monitor.sv
// Scoreboard bench for rv_test_monitor. Each test is a per-cycle program of
// writeback writes; the expected verdict is derived from the program list
// (first done trigger, last writes to the case/pass registers within the
// counted window) and queued; a negedge monitor pops and compares when
// done_o rises.
module tb_rv_test_monitor;
  import rv_tb_pkg::*;

  localparam int S  = 2;
  localparam int T  = 50;
  localparam int PL = 60;

  typedef struct {
    int          rel;
    int          at_edge;
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [31:0] fcase;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        done, pass, fail, tmo;
  logic [31:0] fcase;
  logic [31:0] cnt;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  exp_t exp_q[$];

  logic        p_we[PL];
  logic [4:0]  p_addr[PL];
  logic [31:0] p_data[PL];

  rv_test_monitor_if wb_if();

  rv_test_monitor #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear),
    .wb          (wb_if),
    .done_o      (done),
    .pass_o      (pass),
    .fail_o      (fail),
    .timeout_o   (tmo),
    .fail_case_o (fcase),
    .cycle_cnt_o (cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: compare the verdict when done_o rises.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t m;
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        m = exp_q.pop_front();
        check("done_edge", edge_cnt, m.at_edge);
        check("pass",      pass,     m.pass);
        check("fail",      fail,     m.fail);
        check("timeout",   tmo,      m.tmo);
        check("fail_case", fcase,    m.fcase);
        check("cycle_cnt", cnt,      m.cnt);
        check("pass_fail_excl", pass & fail, 0);
      end
    end
    done_prev = done;
  end

  task automatic prog_clear();
    for (int c = 0; c < PL; c++) begin
      p_we[c] = 1'b0; p_addr[c] = '0; p_data[c] = '0;
    end
  endtask

  task automatic prog_w(input int c, input int a, input logic [31:0] d);
    p_we[c] = 1'b1; p_addr[c] = 5'(a); p_data[c] = d;
  endtask

  // Reference: verdict from the write list.
  function automatic exp_t model();
    exp_t e;
    int k = -1;
    int last;
    logic [31:0] cs = '0;
    logic [31:0] ps = '0;
    for (int c = 0; c < T; c++)
      if (k < 0 && p_we[c] && p_addr[c] == 5'd26 && p_data[c] == 32'd1) k = c;
    last = (k >= 0) ? k + S + 1 : T - 2;
    for (int c = 0; c <= last; c++) begin
      if (p_we[c] && p_addr[c] == 5'd3)  cs = p_data[c];
      if (p_we[c] && p_addr[c] == 5'd27) ps = p_data[c];
    end
    e.at_edge = 0;
    if (k >= 0) begin
      e.pass  = (ps == 32'd1);
      e.fail  = !e.pass;
      e.tmo   = 1'b0;
      e.fcase = e.pass ? 32'd0 : cs;
      e.cnt   = 32'(k + S + 2);
      e.rel   = k + S + 3;
    end else begin
      e.pass  = 1'b0;
      e.fail  = 1'b1;
      e.tmo   = 1'b1;
      e.fcase = cs;
      e.cnt   = 32'(T - 1);
      e.rel   = T;
    end
    return e;
  endfunction

  task automatic drive_cycle(input int c);
    wb_if.wb_we_i   = p_we[c];
    wb_if.wb_addr_i = p_addr[c];
    wb_if.wb_data_i = p_data[c];
    @(posedge clk); #1;
  endtask

  // Clear, then play the program. With stop_at >= 0 the run is abandoned
  // after that cycle (no verdict expected). With dirty set, the clear cycle
  // also carries a passing write that must be discarded.
  task automatic run_prog(input bit dirty, input int stop_at);
    exp_t e;
    int start;
    int last;
    e = model();
    clear = 1'b1;
    wb_if.wb_we_i   = dirty;
    wb_if.wb_addr_i = 5'd27;
    wb_if.wb_data_i = 32'd1;
    @(posedge clk); #1;
    clear = 1'b0;
    start = edge_cnt;
    check("clr_cnt",   cnt,   0);
    check("clr_done",  done,  0);
    check("clr_tmo",   tmo,   0);
    check("clr_fcase", fcase, 0);
    if (stop_at < 0) begin
      e.at_edge = start + e.rel;
      exp_q.push_back(e);
    end
    last = (stop_at < 0) ? PL - 1 : stop_at;
    for (int c = 0; c <= last; c++) drive_cycle(c);
    wb_if.wb_we_i = 1'b0;
    if (stop_at < 0) begin
      repeat (3) @(posedge clk);
      #1;
      check("verdict_seen", exp_q.size(), 0);
      while (exp_q.size() > 0) void'(exp_q.pop_front());
      check("hold_pass",  pass,  e.pass);
      check("hold_fail",  fail,  e.fail);
      check("hold_tmo",   tmo,   e.tmo);
      check("hold_fcase", fcase, e.fcase);
      check("hold_cnt",   cnt,   e.cnt);
    end
  endtask

  task automatic prog_pass();
    prog_clear(); prog_w(0, 3, 5); prog_w(1, 27, 1); prog_w(2, 26, 1);
  endtask

  initial begin
    int a;
    logic [31:0] d;
    wb_if.wb_we_i = 1'b0; wb_if.wb_addr_i = '0; wb_if.wb_data_i = '0;
    #12;
    check("rst_done", done, 0);
    check("rst_cnt",  cnt,  0);
    check("rst_fcase", fcase, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass, fail, late pass write, writes after done.
    prog_pass(); run_prog(0, -1);
    prog_clear(); prog_w(0, 3, 7); prog_w(1, 27, 0); prog_w(2, 26, 1); run_prog(0, -1);
    prog_clear(); prog_w(2, 26, 1); prog_w(4, 27, 1); prog_w(20, 27, 0); prog_w(40, 27, 0);
    run_prog(0, -1);

    // Watchdog, and trigger on the last permitted cycle.
    prog_clear(); prog_w(0, 3, 9); run_prog(0, -1);
    prog_clear(); prog_w(0, 3, 9); prog_w(49, 26, 1); run_prog(0, -1);

    // Wrong done value and x0 writes never complete.
    prog_clear(); prog_w(0, 26, 2);
    for (int c = 1; c < 12; c++) prog_w(c, 0, 1);
    run_prog(0, -1);

    // Clear while in SETTLE, with a pass write on the clear cycle.
    prog_clear(); prog_w(0, 27, 1); prog_w(2, 26, 1); run_prog(0, 3);
    prog_clear(); prog_w(0, 3, 11); prog_w(1, 26, 1); run_prog(1, -1);

    // Asynchronous reset mid-SETTLE and after a failing verdict.
    prog_clear(); prog_w(0, 3, 4); prog_w(2, 26, 1); run_prog(0, 3);
    check("pre_rst_cnt", cnt, 4);
    #2 rst_n = 1'b0;
    #1 check("arst_cnt", cnt, 0);
    check("arst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    prog_clear(); prog_w(0, 3, 7); prog_w(2, 26, 1); run_prog(0, -1);
    #2 rst_n = 1'b0;
    #1 check("arst2_fail", fail, 0);
    check("arst2_fcase", fcase, 0);
    check("arst2_done",  done,  0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    prog_pass(); run_prog(0, -1);

    // Random programs.
    for (int r = 0; r < 25; r++) begin
      prog_clear();
      for (int c = 0; c < PL; c++) begin
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 5))
            0:       a = 0;
            1:       a = 3;
            2, 3:    a = 26;
            4:       a = 27;
            default: a = int'($urandom_range(1, 31));
          endcase
          if (a == 26)      d = 32'($urandom_range(0, 2));
          else if (a == 27) d = 32'($urandom_range(0, 1));
          else              d = $urandom;
          prog_w(c, a, d);
        end
      end
      run_prog(0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
